// File: rtl/tlul_pkg.sv
// TL-UL link definitions: channel structs, opcodes, widths and host-side
// constants shared by the host adapter and its tag FIFO.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;

  // Host-side constants: every host beat is a full 32-bit word.
  localparam logic [TL_SZW-1:0] TLUL_HOST_SIZE_WORD = 2'd2;
  localparam logic [TL_DBW-1:0] TLUL_FULL_MASK      = 4'hF;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // A full-mask write is a PutFullData; any other write is partial.
  function automatic tl_a_op_e host_a_opcode(input logic we, input logic [TL_DBW-1:0] be);
    tl_a_op_e op;
    if (!we) begin
      op = Get;
    end else if (be == TLUL_FULL_MASK) begin
      op = PutFullData;
    end else begin
      op = PutPartialData;
    end
    return op;
  endfunction

endpackage

// File: rtl/tlul_host_tag_fifo.sv
// Small synchronous FIFO holding the expected {source, is_read} of each
// outstanding request, popped in order as D beats come back.
module tlul_host_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  assign rdata_o = mem[rd_ptr];
  assign full_o  = (cnt == CNT_FULL);
  assign empty_o = (cnt == '0);

  // Storage write; contents need no reset because cnt guards every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_i) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_adapter.sv
// Core req/gnt/rvalid port to TL-UL host bridge with up to MAX_OUTSTANDING
// in-order requests. Define TLUL_HOST_RSP_CHECK_EN to check D-channel
// source/opcode against a tag FIFO and flag spurious beats.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int SRC_BASE        = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);

  localparam logic [0:0] A_IDLE = 1'b0;
  localparam logic [0:0] A_PEND = 1'b1;

  localparam int CNT_W = 3;
  localparam int TAG_W = 2;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0]  TAG_LAST = TAG_W'(MAX_OUTSTANDING - 1);
  localparam logic [TL_AIW-1:0] SRC_OFS  = TL_AIW'(SRC_BASE);

  logic [0:0]        a_state;
  logic [CNT_W-1:0]  out_cnt;
  logic [TAG_W-1:0]  tag;

  tl_a_op_e          a_opcode_q;
  logic [TL_SZW-1:0] a_size_q;
  logic [TL_AIW-1:0] a_source_q;
  logic [TL_AW-1:0]  a_address_q;
  logic [TL_DBW-1:0] a_mask_q;
  logic [TL_DW-1:0]  a_data_q;

  logic              a_fire;
  logic              d_beat;
  logic              d_take;
  logic              d_spur;
  logic [TL_AIW-1:0] next_source;
  logic              rsp_err;
  logic              spur_pulse;

  assign gnt_o = req_i & ~rst_i & ((a_state == A_IDLE) | tl_h_i.a_ready) & (out_cnt < MAX_CNT);

  assign a_fire      = (a_state == A_PEND) & tl_h_i.a_ready;
  assign d_beat      = tl_h_i.d_valid & ~rst_i;
  assign d_take      = d_beat & (out_cnt != '0);
  assign d_spur      = d_beat & (out_cnt == '0);
  assign next_source = SRC_OFS + {{(TL_AIW-TAG_W){1'b0}}, tag};

  // Drive the A channel from the held request registers; d_ready follows reset.
  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = (a_state == A_PEND);
    tl_h_o.a_opcode  = a_opcode_q;
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = a_size_q;
    tl_h_o.a_source  = a_source_q;
    tl_h_o.a_address = a_address_q;
    tl_h_o.a_mask    = a_mask_q;
    tl_h_o.a_data    = a_data_q;
    tl_h_o.d_ready   = ~rst_i;
  end

  // A-channel state: a grant always (re)enters A_PEND; an accepted beat with no new grant idles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_state <= A_IDLE;
    end else if (gnt_o) begin
      a_state <= A_PEND;
    end else if (a_fire) begin
      a_state <= A_IDLE;
    end
  end

  // A request register loads only on grant, so fields stay put under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_opcode_q  <= PutFullData;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else if (gnt_o) begin
      a_opcode_q  <= host_a_opcode(we_i, be_i);
      a_size_q    <= TLUL_HOST_SIZE_WORD;
      a_source_q  <= next_source;
      a_address_q <= {addr_i[31:2], 2'b00};
      a_mask_q    <= we_i ? be_i : TLUL_FULL_MASK;
      a_data_q    <= we_i ? wdata_i : '0;
    end
  end

  // Outstanding counter and rolling tag; spurious D beats never touch the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt <= '0;
      tag     <= '0;
    end else begin
      case ({gnt_o, d_take})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (gnt_o) begin
        tag <= (tag == TAG_LAST) ? '0 : tag + 1'b1;
      end
    end
  end

`ifdef TLUL_HOST_RSP_CHECK_EN
  localparam int FIFO_W = TL_AIW + 1;

  logic [FIFO_W-1:0] exp_entry;
  logic              fifo_full_unused;
  logic              fifo_empty_unused;
  logic              exp_read;
  logic [TL_AIW-1:0] exp_source;
  tl_d_op_e          exp_opcode;

  tlul_host_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (FIFO_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt_o),
    .wdata_i ({next_source, ~we_i}),
    .pop_i   (d_take),
    .rdata_o (exp_entry),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty_unused)
  );

  assign exp_read   = exp_entry[0];
  assign exp_source = exp_entry[FIFO_W-1:1];
  assign exp_opcode = exp_read ? AccessAckData : AccessAck;
  assign rsp_err    = tl_h_i.d_error | (tl_h_i.d_source != exp_source) | (tl_h_i.d_opcode != exp_opcode);
  assign spur_pulse = d_spur;
`else
  assign rsp_err    = tl_h_i.d_error;
  assign spur_pulse = 1'b0;
`endif

  // Registered response: one pulse per D beat, data zeroed for AccessAck, data held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else if (d_take) begin
      rvalid_o <= 1'b1;
      rdata_o  <= (tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : '0;
      err_o    <= rsp_err;
    end else if (spur_pulse) begin
      rvalid_o <= 1'b1;
      rdata_o  <= '0;
      err_o    <= 1'b1;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{addr_i[1:0], tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_source, tl_h_i.d_sink};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed self-checking bench for tlul_host_adapter; the bench itself plays
// the TL-UL device. Expectations follow TLUL_HOST_RSP_CHECK_EN when defined.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

`ifdef TLUL_HOST_RSP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  int passed;
  int total;

  tlul_host_adapter #(
    .MAX_OUTSTANDING (2),
    .SRC_BASE        (0)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .be_i     (be),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .tl_h_o   (h2d),
    .tl_h_i   (d2h)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d);
    req   = r;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
  endtask

  task automatic applyDevice(input logic dv, input tl_d_op_e op, input logic [7:0] src,
                             input logic [31:0] dd, input logic de, input logic ar);
    d2h          = '0;
    d2h.d_valid  = dv;
    d2h.d_opcode = op;
    d2h.d_source = src;
    d2h.d_data   = dd;
    d2h.d_error  = de;
    d2h.a_ready  = ar;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Linear directed sequence: inputs change at negedge, outputs checked 1 ns later.
  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_a_valid", h2d.a_valid, 0);
    checkOutput("rst_d_ready", h2d.d_ready, 0);
    checkOutput("rst_a_address", h2d.a_address, 0);
    checkOutput("rst_a_size", h2d.a_size, 0);
    checkOutput("rst_a_opcode", h2d.a_opcode, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_err", err, 0);

    $display("[TB] single full write");
    rst = 1'b0;
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h1000_0002, 4'hF, 32'h5A);
    #1;
    checkOutput("wr_gnt", gnt, 1);
    checkOutput("wr_d_ready", h2d.d_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAck, 8'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    checkOutput("wr_a_valid", h2d.a_valid, 1);
    checkOutput("wr_opcode", h2d.a_opcode, PutFullData);
    checkOutput("wr_address", h2d.a_address, 32'h1000_0000);
    checkOutput("wr_mask", h2d.a_mask, 4'hF);
    checkOutput("wr_data", h2d.a_data, 32'h5A);
    checkOutput("wr_size", h2d.a_size, 2);
    checkOutput("wr_param", h2d.a_param, 0);
    checkOutput("wr_source", h2d.a_source, 0);
    checkOutput("wr_no_gnt", gnt, 0);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("wr_rvalid", rvalid, 1);
    checkOutput("wr_err", err, 0);
    checkOutput("wr_rdata", rdata, 0);
    checkOutput("wr_a_idle", h2d.a_valid, 0);
    @(negedge clk); #1;
    checkOutput("wr_rvalid_pulse", rvalid, 0);

    $display("[TB] read back");
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 4'h0, 32'hFFFF_FFFF);
    #1;
    checkOutput("rd_gnt", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAckData, 8'h1, 32'h5A, 1'b0, 1'b1);
    #1;
    checkOutput("rd_opcode", h2d.a_opcode, Get);
    checkOutput("rd_mask", h2d.a_mask, 4'hF);
    checkOutput("rd_data", h2d.a_data, 0);
    checkOutput("rd_source", h2d.a_source, 1);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("rd_rvalid", rvalid, 1);
    checkOutput("rd_rdata", rdata, 32'h0000_005A);
    checkOutput("rd_err", err, 0);

    $display("[TB] partial write");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h1000_0004, 4'h3, 32'h1234_ABCD);
    #1;
    checkOutput("pw_gnt", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAck, 8'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    checkOutput("pw_opcode", h2d.a_opcode, PutPartialData);
    checkOutput("pw_mask", h2d.a_mask, 4'h3);
    checkOutput("pw_data", h2d.a_data, 32'h1234_ABCD);
    checkOutput("pw_source", h2d.a_source, 0);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("pw_rvalid", rvalid, 1);
    checkOutput("pw_rdata_zero", rdata, 0);

    $display("[TB] backpressure and outstanding limit");
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h20, 4'hF, 32'h11);
    #1;
    checkOutput("bp_gnt1", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h24, 4'hF, 32'h22);
    #1;
    checkOutput("bp_hold_gnt", gnt, 0);
    checkOutput("bp_a_valid", h2d.a_valid, 1);
    checkOutput("bp_data", h2d.a_data, 32'h11);
    checkOutput("bp_addr", h2d.a_address, 32'h20);
    checkOutput("bp_source", h2d.a_source, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checkOutput("bp_stall_gnt", gnt, 0);
      checkOutput("bp_stall_data", h2d.a_data, 32'h11);
      checkOutput("bp_stall_addr", h2d.a_address, 32'h20);
    end
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_gnt2", gnt, 1);
    checkOutput("bp_data_last", h2d.a_data, 32'h11);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h28, 4'hF, 32'h33);
    #1;
    checkOutput("bp_full_gnt", gnt, 0);
    checkOutput("bp_second_data", h2d.a_data, 32'h22);
    checkOutput("bp_second_source", h2d.a_source, 0);
    @(negedge clk);
    applyDevice(1'b1, AccessAck, 8'h1, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_a_drained", h2d.a_valid, 0);
    checkOutput("bp_full_gnt2", gnt, 0);
    @(negedge clk);
    applyDevice(1'b1, AccessAck, 8'h0, 32'h0, 1'b1, 1'b1);
    #1;
    checkOutput("bp_rsp1_rvalid", rvalid, 1);
    checkOutput("bp_rsp1_err", err, 0);
    checkOutput("bp_gnt3", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAck, 8'h1, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_rsp2_rvalid", rvalid, 1);
    checkOutput("bp_rsp2_d_error", err, 1);
    checkOutput("bp_third_data", h2d.a_data, 32'h33);
    checkOutput("bp_third_source", h2d.a_source, 1);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("bp_rsp3_rvalid", rvalid, 1);
    checkOutput("bp_rsp3_err", err, 0);
    checkOutput("bp_idle", h2d.a_valid, 0);

    $display("[TB] wrong d_source");
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    #1;
    checkOutput("src_gnt", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAckData, 8'h1, 32'h77, 1'b0, 1'b1);
    #1;
    checkOutput("src_a_source", h2d.a_source, 0);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("src_rvalid", rvalid, 1);
    checkOutput("src_rdata", rdata, 32'h77);
    checkOutput("src_err", err, CHK);

    $display("[TB] spurious D beat");
    @(negedge clk);
    applyDevice(1'b1, AccessAckData, 8'h0, 32'h99, 1'b0, 1'b1);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("spur_rvalid", rvalid, CHK);
    checkOutput("spur_err", err, CHK);
    checkOutput("spur_rdata", rdata, CHK ? 32'h0 : 32'h77);

    $display("[TB] reset mid-flight");
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h50, 4'hF, 32'hAA);
    #1;
    checkOutput("mrst_gnt", gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mrst_a_valid_before", h2d.a_valid, 1);
    checkOutput("mrst_gnt_blocked", gnt, 0);
    checkOutput("mrst_d_ready", h2d.d_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAck, 8'h1, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("mrst_a_valid", h2d.a_valid, 0);
    checkOutput("mrst_a_address", h2d.a_address, 0);
    checkOutput("mrst_a_data", h2d.a_data, 0);
    checkOutput("mrst_rvalid", rvalid, 0);
    checkOutput("mrst_rdata", rdata, 0);
    checkOutput("mrst_err", err, 0);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("late_rvalid", rvalid, CHK);
    checkOutput("late_err", err, CHK);

    $display("[TB] tag restarts after reset");
    applyStimulus(1'b1, 1'b0, 32'h60, 4'hF, 32'h0);
    #1;
    checkOutput("post_gnt", gnt, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyDevice(1'b1, AccessAckData, 8'h0, 32'h1234, 1'b0, 1'b1);
    #1;
    checkOutput("post_source", h2d.a_source, 0);
    @(negedge clk);
    applyDevice(1'b0, AccessAck, 8'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("post_rvalid", rvalid, 1);
    checkOutput("post_rdata", rdata, 32'h1234);
    checkOutput("post_err", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
